// File: rtl/gf2m_reduce_b233.sv
// GF(2^233) reduction modulo x^233 + x^74 + 1.
// Folds STEP upper product bits per cycle, top window first.
module gf2m_reduce_b233 #(
  parameter int STEP = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [465:0] c_in,
  output logic [232:0] r,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int N = (233 + STEP - 1) / STEP;
  localparam logic [465:0] ONES = '1;
  localparam logic [7:0] LAST = 8'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    DONE
  } state_t;

  state_t       state;
  logic [465:0] acc;
  logic [465:0] win;
  logic [465:0] hit;
  logic [465:0] nxt;
  logic [7:0]   cnt;
  int           sh;
  int           lo;

  // x^k = x^(k-233) * (x^74 + 1): each set bit in the window lands
  // at k-233 and k-159, both strictly below the window.
  always_comb begin
    sh  = int'(cnt) * STEP;
    lo  = 465 - sh - STEP + 1;
    if (lo < 233) lo = 233;
    win = (ONES >> sh) & (ONES << lo);
    hit = acc & win;
    nxt = (acc & ~win) ^ (hit >> 233) ^ (hit >> 159);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      r         <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            acc      <= c_in;
            cnt      <= '0;
            state    <= REDUCE;
            in_ready <= 1'b0;
          end
        end
        REDUCE: begin
          acc <= nxt;
          cnt <= cnt + 8'd1;
          if (cnt == LAST) begin
            state     <= DONE;
            r         <= nxt[232:0];
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf2m_reduce_b233.sv
// Bench for gf2m_reduce_b233: STEP = 32, 1 and 159 instances.
// Directed and model-checked vectors, back-pressure and reset.
module tb_gf2m_reduce_b233;

  localparam logic [465:0] ONE  = 466'd1;
  localparam logic [232:0] BONE = 233'd1;

  logic         clk;
  logic         rst;
  logic [2:0]   in_valid;
  logic [2:0]   in_ready;
  logic [2:0]   out_valid;
  logic [2:0]   out_ready;
  logic [465:0] c_in [3];
  logic [232:0] r    [3];

  int nvec;
  int nerr;
  int nexp [3];

  gf2m_reduce_b233 #(.STEP(32)) u_s32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .c_in(c_in[0]), .r(r[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0])
  );

  gf2m_reduce_b233 #(.STEP(1)) u_s1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .c_in(c_in[1]), .r(r[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1])
  );

  gf2m_reduce_b233 #(.STEP(159)) u_s159 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .c_in(c_in[2]), .r(r[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [232:0] got,
                       input logic [232:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Plain long division, one bit at a time from the top.
  function automatic logic [232:0] modf(input logic [465:0] c);
    logic [465:0] t;
    t = c;
    for (int k = 465; k >= 233; k--)
      if (|(t & (ONE << k)))
        t = t ^ (ONE << k) ^ (ONE << (k - 159)) ^ (ONE << (k - 233));
    return t[232:0];
  endfunction

  function automatic logic [465:0] clmul(input logic [232:0] a,
                                         input logic [232:0] b);
    logic [465:0] p;
    p = '0;
    for (int i = 0; i < 233; i++)
      if (|(b & (BONE << i)))
        p = p ^ ({233'd0, a} << i);
    return p;
  endfunction

  function automatic logic [232:0] rnd233();
    logic [255:0] t;
    t = '0;
    for (int j = 0; j < 8; j++)
      t = (t << 32) | 256'($urandom());
    return t[232:0];
  endfunction

  task automatic apply(input int idx,
                       input logic [465:0] c,
                       input logic [232:0] exp,
                       input string tag);
    int cyc;
    cyc = 0;
    @(negedge clk);
    in_valid[idx] = 1'b1;
    c_in[idx] = c;
    @(posedge clk);
    #1;
    in_valid[idx] = 1'b0;
    c_in[idx] = '1;
    while (!out_valid[idx] && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_lat"}, 233'(cyc), 233'(nexp[idx]));
    check(tag, r[idx], exp);
    @(negedge clk);
    out_ready[idx] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[idx] = 1'b0;
    check({tag, "_rdy"}, 233'(in_ready[idx]), 233'd1);
  endtask

  initial begin
    logic [232:0] a;
    logic [232:0] b;
    logic [465:0] p;
    logic         seen;
    int           cyc;

    nvec = 0;
    nerr = 0;
    nexp[0] = 8;
    nexp[1] = 233;
    nexp[2] = 2;
    rst = 1'b1;
    in_valid = '0;
    out_ready = '0;
    for (int i = 0; i < 3; i++) c_in[i] = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ir", 233'(in_ready[0]), 233'd1);
    check("rst_ov", 233'(out_valid[0]), 233'd0);
    check("rst_r", r[0], 233'd0);
    @(negedge clk);
    rst = 1'b0;

    apply(0, ONE << 233, (BONE << 74) | BONE, "x233");
    apply(0, ONE << 465,
          (BONE << 232) | (BONE << 147) | (BONE << 73), "x465");
    apply(0, 466'h5, 233'h5, "low5");
    apply(0, 466'd0, 233'd0, "zero");
    apply(0, (ONE << 300) | (ONE << 240) | ONE,
          (BONE << 141) | (BONE << 67) | (BONE << 81) |
          (BONE << 7) | BONE, "mix");

    for (int v = 0; v < 4; v++) begin
      a = rnd233();
      b = rnd233();
      p = clmul(a, b);
      apply(0, p, modf(p), "rnd32");
      apply(1, p, modf(p), "rnd1");
      apply(2, p, modf(p), "rnd159");
    end
    apply(1, ONE << 465,
          (BONE << 232) | (BONE << 147) | (BONE << 73), "s1_x465");
    apply(2, ONE << 465,
          (BONE << 232) | (BONE << 147) | (BONE << 73), "s159_x465");

    // Back-pressure with a stray in_valid that must be ignored.
    @(negedge clk);
    in_valid[0] = 1'b1;
    c_in[0] = ONE << 233;
    @(posedge clk);
    #1;
    c_in[0] = ONE << 300;
    cyc = 0;
    while (!out_valid[0] && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("bp_lat", 233'(cyc), 233'd8);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_r", r[0], (BONE << 74) | BONE);
      check("bp_ov", 233'(out_valid[0]), 233'd1);
      check("bp_ir", 233'(in_ready[0]), 233'd0);
    end
    @(negedge clk);
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    check("bp_rel_ir", 233'(in_ready[0]), 233'd1);
    check("bp_rel_ov", 233'(out_valid[0]), 233'd0);

    // Reset landing on iteration 3 of a reduction.
    @(negedge clk);
    in_valid[0] = 1'b1;
    c_in[0] = ONE << 465;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_ir", 233'(in_ready[0]), 233'd1);
    check("mid_ov", 233'(out_valid[0]), 233'd0);
    check("mid_r", r[0], 233'd0);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      seen = seen | out_valid[0];
    end
    check("mid_nopulse", 233'(seen), 233'd0);
    a = rnd233();
    b = rnd233();
    p = clmul(a, b);
    apply(0, p, modf(p), "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
